// File: rtl/channel_arbiter_rr_n.sv
// N-input valid/ready arbiter with a registered output slice: input 0 is an optional burst-limited
// strict-priority port, the rest share round-robin. Define CHANNEL_ARBITER_PERF_EN for the perf counters.
module channel_arbiter_rr_n #(
  parameter int NUM_IN        = 4,
  parameter int DWIDTH        = 9,
  parameter int PRIORITY_IN0  = 1,
  parameter int MAX_IN0_BURST = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN*DWIDTH-1:0]    in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DWIDTH-1:0]           out_data,
  output logic [$clog2(NUM_IN)-1:0]   out_src,
  input  logic                        out_ready,
  output logic [NUM_IN*CNT_WIDTH-1:0] grant_cnt,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);
  localparam int SRC_W   = $clog2(NUM_IN);
  localparam int BURST_W = $clog2(MAX_IN0_BURST + 1);
  localparam logic [SRC_W-1:0]   RR_START  = (PRIORITY_IN0 != 0) ? SRC_W'(1) : SRC_W'(0);
  localparam logic [SRC_W-1:0]   LAST_IDX  = SRC_W'(NUM_IN - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_IN0_BURST);

  logic                 load;
  logic                 others_valid;
  logic                 pri_win;
  logic                 xfer;
  logic                 rr_found;
  logic [NUM_IN-1:0]    rr_grant;
  logic [NUM_IN-1:0]    grant;
  logic [SRC_W-1:0]     rr_idx;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     next_ptr;
  logic [SRC_W-1:0]     rr_ptr;
  logic [BURST_W-1:0]   burst_cnt;
  logic [DWIDTH-1:0]    sel_data;

  assign load         = !out_valid || out_ready;
  assign others_valid = |in_valid[NUM_IN-1:1];
  assign pri_win      = (PRIORITY_IN0 != 0) && in_valid[0] &&
                        ((burst_cnt < BURST_MAX) || !others_valid);

  // First valid requester at or after rr_ptr, skipping the priority port when it is reserved.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      rr_idx = SRC_W'((int'(rr_ptr) + k) % NUM_IN);
      if (!rr_found && in_valid[rr_idx] && !((PRIORITY_IN0 != 0) && (rr_idx == '0))) begin
        rr_grant[rr_idx] = 1'b1;
        rr_found         = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load) begin
      grant = pri_win ? {{(NUM_IN-1){1'b0}}, 1'b1} : rr_grant;
    end
  end

  assign in_ready = grant;
  assign xfer     = |grant;

  always_comb begin
    grant_idx = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        grant_idx = SRC_W'(i);
        sel_data  = in_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign next_ptr = (grant_idx == LAST_IDX) ? RR_START : grant_idx + SRC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Burst count only grows while input 0 is actually holding others off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= RR_START;
      burst_cnt <= '0;
    end else if (xfer) begin
      if (grant[0] && (PRIORITY_IN0 != 0)) begin
        if (others_valid) begin
          burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BURST_W'(1);
        end else begin
          burst_cnt <= '0;
        end
      end else begin
        burst_cnt <= '0;
        rr_ptr    <= next_ptr;
      end
    end
  end

`ifdef CHANNEL_ARBITER_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant[i] && (grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX)) begin
          grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
        end
      end
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign grant_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
